// File: rtl/nd_1ton.sv
// -----------------------------------------------------------------------------
// nd_1ton : one input channel fanned out to NOUT output channels.
//
// Each accepted message is routed by its dst field into one per-output FIFO,
// or copied into all of them when dst matches the broadcast address. Every
// output runs its own four-phase handshake FSM, so a stalled sink only blocks
// the input when its own FIFO is full, or when a broadcast needs it.
//
// Ports:
//   i_clk      clock
//   reset      synchronous, active-low (0 = reset)
//   ready      node initialised and operational
//   snd_req    per-output request
//   snd_ack    per-output acknowledge
//   snd_src    packed source,      slice i = snd_src[i*ASZ +: ASZ]
//   snd_dst    packed destination, slice i = snd_dst[i*ASZ +: ASZ]
//   snd_dat    packed data,        slice i = snd_dat[i*DSZ +: DSZ]
//   snd_red    packed redundancy,  slice i = snd_red[i*RSZ +: RSZ]
//   rcv_req    input request
//   rcv_ack    input acknowledge
//   rcv_src    input source
//   rcv_dst    input destination (routing key)
//   rcv_dat    input data
//   rcv_red    input redundancy
//   bcast_cnt  broadcasts accepted since reset, saturating at 16'hFFFF
// -----------------------------------------------------------------------------
module nd_1ton #(
    parameter int                      NOUT       = 4,
    parameter int                      MODE       = 0,   // 0: range table, 1: bit select
    parameter int                      ASZ        = 8,   // address width
    parameter int                      DSZ        = 32,  // data width
    parameter int                      RSZ        = 4,   // redundancy width
    parameter logic [(NOUT-1)*ASZ-1:0] BOUNDS     = {8'hC0, 8'h80, 8'h40},
    parameter int                      SEL_LSB    = 0,
    parameter bit                      BCAST_EN   = 1'b1,
    parameter logic [ASZ-1:0]          BCAST_ADDR = '1,
    parameter int                      FSZ        = 4    // FIFO depth, power of 2, >= 2
) (
    input  logic                i_clk,
    input  logic                reset,
    output logic                ready,
    output logic [NOUT-1:0]     snd_req,
    input  logic [NOUT-1:0]     snd_ack,
    output logic [NOUT*ASZ-1:0] snd_src,
    output logic [NOUT*ASZ-1:0] snd_dst,
    output logic [NOUT*DSZ-1:0] snd_dat,
    output logic [NOUT*RSZ-1:0] snd_red,
    input  logic                rcv_req,
    output logic                rcv_ack,
    input  logic [ASZ-1:0]      rcv_src,
    input  logic [ASZ-1:0]      rcv_dst,
    input  logic [DSZ-1:0]      rcv_dat,
    input  logic [RSZ-1:0]      rcv_red,
    output logic [15:0]         bcast_cnt
);

    localparam int SW = (NOUT > 1) ? $clog2(NOUT) : 1;  // output index width
    localparam int PW = $clog2(FSZ);                     // FIFO pointer width
    localparam int CW = $clog2(FSZ + 1);                 // FIFO count width (0..FSZ)

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_LOW
    } ostate_t;

    typedef struct packed {
        logic [ASZ-1:0] src;
        logic [ASZ-1:0] dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
    } msg_t;

    msg_t          mem     [NOUT][FSZ];
    logic [PW-1:0] wr_ptr  [NOUT];
    logic [PW-1:0] rd_ptr  [NOUT];
    logic [CW-1:0] count   [NOUT];
    ostate_t       state   [NOUT];
    ostate_t       state_d [NOUT];
    msg_t          out_msg [NOUT];

    msg_t            in_msg;
    logic            is_bcast;
    logic [SW-1:0]   tgt;
    logic [NOUT-1:0] has_space;
    logic            all_space;
    logic            accept;
    logic [NOUT-1:0] push;
    logic [NOUT-1:0] pop;

    assign in_msg = '{src: rcv_src, dst: rcv_dst, dat: rcv_dat, red: rcv_red};

    // Route decode. Broadcast overrides the unicast target.
    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        is_bcast = BCAST_EN && (rcv_dst == BCAST_ADDR);
        tgt      = SW'(NOUT - 1);
        if (MODE == 0) begin
            // Walk from the top down so the lowest matching bound wins.
            for (int i = NOUT - 2; i >= 0; i--) begin
                if (rcv_dst < BOUNDS[i*ASZ +: ASZ]) tgt = SW'(i);
            end
        end else begin
            tgt = rcv_dst[SEL_LSB +: SW];
        end
    end

    // Fullness is judged from registered counts only, so a pop on this edge
    // does not make room for a push on the same edge.
    always_comb begin
        all_space = 1'b1;
        has_space = '0;
        for (int i = 0; i < NOUT; i++) begin
            has_space[i] = (count[i] < CW'(FSZ));
            all_space    = all_space & has_space[i];
        end
        accept = ready && rcv_req && !rcv_ack &&
                 (is_bcast ? all_space : has_space[tgt]);
        push = '0;
        pop  = '0;
        for (int i = 0; i < NOUT; i++) begin
            push[i] = accept && (is_bcast || (tgt == SW'(i)));
            // Pop only once the previous four-phase cycle has fully closed.
            pop[i]  = ready && (state[i] == S_IDLE) && (count[i] != '0) && !snd_ack[i];
        end
    end

    // Output handshake FSMs, next-state logic.
    always_comb begin
        for (int i = 0; i < NOUT; i++) begin
            state_d[i] = state[i];
            unique case (state[i])
                S_IDLE:     if (pop[i])      state_d[i] = S_REQ;
                S_REQ:      if (snd_ack[i])  state_d[i] = S_WAIT_LOW;
                S_WAIT_LOW: if (!snd_ack[i]) state_d[i] = S_IDLE;
                default:                     state_d[i] = S_IDLE;
            endcase
        end
    end

    // Output handshake FSMs, state register.
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NOUT; i++) begin
            if (!reset || !ready) state[i] <= S_IDLE;
            else                  state[i] <= state_d[i];
        end
    end

    // Control path: pointers, counts, handshakes, output registers.
    // The first edge after reset is released runs the same clear as reset and
    // raises ready, so nothing is accepted on that edge.
    always_ff @(posedge i_clk) begin
        if (!reset || !ready) begin
            ready     <= reset;
            rcv_ack   <= 1'b0;
            bcast_cnt <= '0;
            snd_req   <= '0;
            for (int i = 0; i < NOUT; i++) begin
                wr_ptr[i]  <= '0;
                rd_ptr[i]  <= '0;
                count[i]   <= '0;
                out_msg[i] <= '0;
            end
        end else begin
            if (accept) begin
                rcv_ack <= 1'b1;
                if (is_bcast && (bcast_cnt != 16'hFFFF)) bcast_cnt <= bcast_cnt + 16'd1;
            end else if (!rcv_req && rcv_ack) begin
                rcv_ack <= 1'b0;
            end

            for (int i = 0; i < NOUT; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;

                if (pop[i]) begin
                    rd_ptr[i]  <= rd_ptr[i] + 1'b1;
                    out_msg[i] <= mem[i][rd_ptr[i]];
                    snd_req[i] <= 1'b1;
                end else if ((state[i] == S_REQ) && snd_ack[i]) begin
                    snd_req[i] <= 1'b0;
                end

                unique case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
            end
        end
    end

    // FIFO storage.
    // NOTE: the message array has no reset; emptiness is tracked by the
    // pointers and counts, so stale entries are never observed.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NOUT; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_msg;
        end
    end

    for (genvar g = 0; g < NOUT; g++) begin : g_pack
        assign snd_src[g*ASZ +: ASZ] = out_msg[g].src;
        assign snd_dst[g*ASZ +: ASZ] = out_msg[g].dst;
        assign snd_dat[g*DSZ +: DSZ] = out_msg[g].dat;
        assign snd_red[g*RSZ +: RSZ] = out_msg[g].red;
    end

endmodule

// File: tb/tb_nd_1ton.sv
// -----------------------------------------------------------------------------
// tb_nd_1ton : scoreboard bench for nd_1ton.
//
// dut0 uses the default configuration (range routing, 4 outputs, FIFO depth 4).
// Stimulus pushes expected messages per output into queues using a reference
// routing function; a monitor pops and compares on every rising snd_req.
// dut1 runs bit-select routing (MODE=1, SEL_LSB=2) with instantly-acking sinks.
// -----------------------------------------------------------------------------
module tb_nd_1ton;

    localparam int N = 4;

    typedef struct packed {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [31:0] dat;
        logic [3:0]  red;
    } msg_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut0 signals
    logic          reset;
    logic          ready;
    logic [N-1:0]  snd_req;
    logic [N-1:0]  snd_ack;
    logic [N*8-1:0]  snd_src;
    logic [N*8-1:0]  snd_dst;
    logic [N*32-1:0] snd_dat;
    logic [N*4-1:0]  snd_red;
    logic          rcv_req;
    logic          rcv_ack;
    logic [7:0]    rcv_src;
    logic [7:0]    rcv_dst;
    logic [31:0]   rcv_dat;
    logic [3:0]    rcv_red;
    logic [15:0]   bcast_cnt;

    // dut1 signals
    logic          ready1;
    logic [N-1:0]  s1_req;
    logic [N-1:0]  s1_ack;
    logic [N*8-1:0]  s1_src;
    logic [N*8-1:0]  s1_dst;
    logic [N*32-1:0] s1_dat;
    logic [N*4-1:0]  s1_red;
    logic          r1_req;
    logic          r1_ack;
    logic [7:0]    r1_src;
    logic [7:0]    r1_dst;
    logic [31:0]   r1_dat;
    logic [3:0]    r1_red;
    logic [15:0]   bc1;

    assign s1_ack = s1_req;

    nd_1ton #(.NOUT(4), .MODE(0), .ASZ(8), .DSZ(32), .RSZ(4), .FSZ(4)) dut0 (
        .i_clk(clk), .reset(reset), .ready(ready),
        .snd_req(snd_req), .snd_ack(snd_ack), .snd_src(snd_src), .snd_dst(snd_dst),
        .snd_dat(snd_dat), .snd_red(snd_red),
        .rcv_req(rcv_req), .rcv_ack(rcv_ack), .rcv_src(rcv_src), .rcv_dst(rcv_dst),
        .rcv_dat(rcv_dat), .rcv_red(rcv_red), .bcast_cnt(bcast_cnt)
    );

    nd_1ton #(.NOUT(4), .MODE(1), .SEL_LSB(2), .ASZ(8), .DSZ(32), .RSZ(4), .FSZ(4)) dut1 (
        .i_clk(clk), .reset(reset), .ready(ready1),
        .snd_req(s1_req), .snd_ack(s1_ack), .snd_src(s1_src), .snd_dst(s1_dst),
        .snd_dat(s1_dat), .snd_red(s1_red),
        .rcv_req(r1_req), .rcv_ack(r1_ack), .rcv_src(r1_src), .rcv_dst(r1_dst),
        .rcv_dat(r1_dat), .rcv_red(r1_red), .bcast_cnt(bc1)
    );

    int   total = 0;
    int   bad   = 0;
    int   bc_exp = 0;
    msg_t exp_q [N][$];
    bit   hold [N];
    bit   rand_stall = 1'b0;
    time  rise_time [N];
    time  last_ack_time = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference routing: -1 means broadcast to every output.
    function automatic int ref_route(input logic [7:0] d);
        if (d == 8'hFF) return -1;
        if (d < 8'h40)  return 0;
        if (d < 8'h80)  return 1;
        if (d < 8'hC0)  return 2;
        return 3;
    endfunction

    function automatic msg_t out_msg(input int i);
        msg_t m;
        m.src = snd_src[i*8 +: 8];
        m.dst = snd_dst[i*8 +: 8];
        m.dat = snd_dat[i*32 +: 32];
        m.red = snd_red[i*4 +: 4];
        return m;
    endfunction

    function automatic msg_t rand_msg(input logic [7:0] dst);
        msg_t m;
        m.src = 8'($urandom);
        m.dst = dst;
        m.dat = $urandom;
        m.red = 4'($urandom);
        return m;
    endfunction

    // Monitor and sinks: compare on every rising snd_req, ack follows req
    // one cycle later unless the sink is held or randomly stalling.
    initial begin
        logic [N-1:0] prev_req;
        msg_t exp_m;
        snd_ack  = '0;
        prev_req = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if ((snd_req[i] === 1'b1) && !prev_req[i]) begin
                    rise_time[i] = $time;
                    check($sformatf("out%0d_expected_pending", i),
                          64'(exp_q[i].size() != 0), 64'd1);
                    if (exp_q[i].size() != 0) begin
                        exp_m = exp_q[i].pop_front();
                        check($sformatf("out%0d_payload", i), 64'(out_msg(i)), 64'(exp_m));
                    end
                end
                prev_req[i] = (snd_req[i] === 1'b1);
                if (!hold[i] && (snd_ack[i] != prev_req[i]) &&
                    (!rand_stall || ($urandom_range(0, 1) == 1)))
                    snd_ack[i] = prev_req[i];
            end
        end
    end

    task automatic issue(input msg_t m);
        int o;
        o = ref_route(m.dst);
        if (o < 0) begin
            for (int k = 0; k < N; k++) exp_q[k].push_back(m);
            bc_exp++;
        end else begin
            exp_q[o].push_back(m);
        end
        rcv_src = m.src;
        rcv_dst = m.dst;
        rcv_dat = m.dat;
        rcv_red = m.red;
        rcv_req = 1'b1;
    endtask

    task automatic complete(input string name);
        int n;
        n = 0;
        while ((rcv_ack !== 1'b1) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ack"}, 64'(rcv_ack === 1'b1), 64'd1);
        last_ack_time = $time;
        rcv_req = 1'b0;
        n = 0;
        while ((rcv_ack !== 1'b0) && (n < 400)) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic send(input string name, input msg_t m);
        issue(m);
        complete(name);
    endtask

    task automatic wait_drain(input string name);
        int n;
        int left;
        n = 0;
        left = 1;
        while ((left != 0) && (n < 3000)) begin
            @(negedge clk);
            n++;
            left = 0;
            for (int k = 0; k < N; k++) left += exp_q[k].size();
            if (snd_req !== '0) left++;
        end
        check({name, "_drained"}, 64'(left), 64'd0);
    endtask

    task automatic mode1_route(input logic [7:0] dst, input int exp_out);
        int   got;
        int   n;
        msg_t m;
        m = rand_msg(dst);
        r1_src = m.src;
        r1_dst = m.dst;
        r1_dat = m.dat;
        r1_red = m.red;
        r1_req = 1'b1;
        got = -1;
        n = 0;
        while ((got < 0) && (n < 40)) begin
            @(negedge clk);
            n++;
            if (r1_ack === 1'b1) r1_req = 1'b0;
            for (int k = 0; k < N; k++) if ((s1_req[k] === 1'b1) && (got < 0)) got = k;
        end
        check($sformatf("mode1_dst%0h_out", dst), 64'(got), 64'(exp_out));
        if (got >= 0) check($sformatf("mode1_dst%0h_dat", dst), 64'(s1_dat[got*32 +: 32]), 64'(m.dat));
        r1_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] route_dst [6];
        int         route_out [6];
        msg_t       m;
        logic [7:0] d;

        route_dst = '{8'h10, 8'h40, 8'h7F, 8'hBF, 8'hC0, 8'hFE};
        route_out = '{0, 1, 1, 2, 3, 3};

        reset   = 1'b0;
        rcv_req = 1'b0;
        rcv_src = '0; rcv_dst = '0; rcv_dat = '0; rcv_red = '0;
        r1_req  = 1'b0;
        r1_src  = '0; r1_dst = '0; r1_dat = '0; r1_red = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready",   64'(ready),     64'd0);
        check("rst_snd_req", 64'(snd_req),   64'd0);
        check("rst_rcv_ack", 64'(rcv_ack),   64'd0);
        check("rst_bcast",   64'(bcast_cnt), 64'd0);
        check("rst_snd_dat", 64'(snd_dat[63:0]), 64'd0);

        // Release reset with a request already pending: no ack on the init edge.
        issue(rand_msg(8'h10));
        reset = 1'b1;
        @(negedge clk);
        check("init_ready",  64'(ready),   64'd1);
        check("init_no_ack", 64'(rcv_ack), 64'd0);
        complete("init_msg");
        wait_drain("init");

        // Range routing, including each bound edge; snd_req one edge after accept.
        foreach (route_dst[j]) begin
            send($sformatf("route_%0h", route_dst[j]), rand_msg(route_dst[j]));
            repeat (2) @(negedge clk);
            check($sformatf("route_%0h_out", route_dst[j]),
                  64'(rise_time[route_out[j]]), 64'(last_ack_time + 10));
        end
        m = rand_msg(8'hE7);
        send("hold_regs", m);
        wait_drain("route");
        check("hold_regs_dat", 64'(snd_dat[3*32 +: 32]), 64'(m.dat));

        // Output 2 stalls: 1 in flight + 4 queued, the next one is refused.
        hold[2] = 1'b1;
        for (int j = 0; j < 5; j++) send($sformatf("bp_%0d", j), rand_msg(8'h90));
        issue(rand_msg(8'h90));
        repeat (20) @(negedge clk);
        check("bp_full_no_ack", 64'(rcv_ack), 64'd0);
        check("bp_out0_idle",   64'(snd_req[0]), 64'd0);
        hold[2] = 1'b0;
        complete("bp_6th");
        send("bp_behind", rand_msg(8'h05));
        wait_drain("bp");

        // Broadcast with all FIFOs empty: every output rises together.
        send("bc1", rand_msg(8'hFF));
        repeat (2) @(negedge clk);
        check("bc1_latency", 64'(rise_time[0]), 64'(last_ack_time + 10));
        for (int k = 1; k < N; k++)
            check($sformatf("bc1_same_cycle_%0d", k), 64'(rise_time[k]), 64'(rise_time[0]));
        check("bc1_cnt", 64'(bcast_cnt), 64'(bc_exp));
        wait_drain("bc1");

        // Broadcast with FIFO 3 full must wait until FIFO 3 pops.
        hold[3] = 1'b1;
        for (int j = 0; j < 5; j++) send($sformatf("bcf_%0d", j), rand_msg(8'hD0));
        issue(rand_msg(8'hFF));
        repeat (20) @(negedge clk);
        check("bcf_no_ack", 64'(rcv_ack),   64'd0);
        check("bcf_cnt_hold", 64'(bcast_cnt), 64'(bc_exp - 1));
        hold[3] = 1'b0;
        complete("bcf_bcast");
        check("bcf_cnt", 64'(bcast_cnt), 64'(bc_exp));
        wait_drain("bcf");

        // Random traffic with random sink stalls.
        rand_stall = 1'b1;
        for (int j = 0; j < 80; j++) begin
            d = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
            send($sformatf("rnd_%0d", j), rand_msg(d));
        end
        wait_drain("rnd");
        rand_stall = 1'b0;
        check("rnd_bcast_cnt", 64'(bcast_cnt), 64'(bc_exp));

        // Reset mid-transfer discards in-flight and queued messages.
        hold[1] = 1'b1;
        for (int j = 0; j < 3; j++) send($sformatf("mid_%0d", j), rand_msg(8'h50));
        repeat (3) @(negedge clk);
        check("mid_req1_busy", 64'(snd_req[1]), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_req",   64'(snd_req),   64'd0);
        check("mid_rst_ack",   64'(rcv_ack),   64'd0);
        check("mid_rst_ready", 64'(ready),     64'd0);
        check("mid_rst_bcast", 64'(bcast_cnt), 64'd0);
        for (int k = 0; k < N; k++) exp_q[k].delete();
        bc_exp  = 0;
        hold[1] = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        check("mid_reinit_ready", 64'(ready), 64'd1);
        repeat (20) @(negedge clk);
        check("mid_no_stale_req", 64'(snd_req), 64'd0);
        check("mid_dat_cleared",  64'(snd_dat[1*32 +: 32]), 64'd0);
        send("mid_fresh", rand_msg(8'h50));
        wait_drain("mid");

        // Bit-select routing on dut1.
        mode1_route(8'b0000_1100, 3);
        mode1_route(8'b0000_0100, 1);
        for (int j = 0; j < 6; j++) begin
            d = 8'($urandom_range(0, 254));
            mode1_route(d, int'(d[3:2]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
